hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage core, sitting beside the ID/EX/MEM/WB pipeline registers. It generates operand-forwarding selects for N source operands in both the EX and ID stages. It also owns the stall/flush sequencing:
- load-use bubbles, with a configurable bubble count
- whole-pipe freeze while data memory is busy
- taken-branch squash

A saturating counter records load-use bubble cycles for performance analysis.

## Interface
- REG_AW, 3, register-specifier width (2^REG_AW architectural registers; no hard-wired zero register)
- NUM_RD, 2, source operands checked per instruction
- LOAD_STALL_CYC, 1, bubbles inserted per load-use hazard (≥1)
- CNT_W, 16, width of the stall counter
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- dec_ReadReg  in  NUM_RD*REG_AW  ID-stage source specifiers; operand i at [i*REG_AW +: REG_AW]
- dec_ReadEn  in  NUM_RD  ID source i actually read
- exe_ReadReg  in  NUM_RD*REG_AW  EX-stage source specifiers, same packing
- exe_ReadEn  in  NUM_RD  EX source i actually read
- exe_RegWrite, exe_DMemRead  in  1 each  EX instruction writes a register / is a load
- exe_WriteReg  in  REG_AW  EX destination
- exe_BranchTaken  in  1  EX resolved a taken branch/jump
- mem_RegWrite, mem_DMemRead  in  1 each  MEM-stage equivalents
- mem_WriteReg  in  REG_AW  MEM destination
- mem_Busy  in  1  data memory not ready this cycle
- wb_RegWrite  in  1  WB writes a register
- wb_WriteReg  in  REG_AW  WB destination
- exe_FwdSel  out  2*NUM_RD  per EX operand, at [2i+1:2i]: 00 register file, 01 MEM-stage ALU result, 10 WB result
- dec_FwdSel  out  2*NUM_RD  per ID operand, same encoding
- stall_PC, stall_IFID  out  1 each  hold PC / IF-ID register
- bubble_IDEX  out  1  load NOP into ID/EX
- stall_IDEX, stall_EXMEM, stall_MEMWB  out  1 each  hold those registers (memory freeze)
- flush_IFID, flush_IDEX  out  1 each  squash on taken branch
- hazard_State  out  2  FSM state encoding: RUN=00, LDSTALL=01, MEMWAIT=10
- hazard_StallCnt  out  CNT_W  saturating count of load-use bubble cycles

## Operation
Forwarding is combinational, per operand i.
- A MEM match is mem_RegWrite & ~mem_DMemRead & mem_WriteReg==src.
- A WB match is wb_RegWrite & wb_WriteReg==src.
- Select: MEM match → 01, else WB match → 10, else 00. The youngest producer wins.
- Operands with ReadEn=0 → 00.
- Outputs are identical for the exe_ and dec_ sets, each evaluated on its own specifier.

Load-use detection:
- A hazard exists when exe_DMemRead & exe_RegWrite and exe_WriteReg equals any enabled dec_ReadReg.

FSM states: RUN, LDSTALL, MEMWAIT. Priority: mem_Busy > exe_BranchTaken > load-use.
- **RUN**
  - mem_Busy=1: assert stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, stall_MEMWB; go to MEMWAIT. Branch and load-use outputs are suppressed.
  - Else exe_BranchTaken=1: assert flush_IFID and flush_IDEX for this cycle and stay in RUN. Load-use is ignored because the ID instruction is squashed.
  - Else load-use: assert stall_PC, stall_IFID, bubble_IDEX and increment the counter. If LOAD_STALL_CYC>1, load the down-counter with LOAD_STALL_CYC-1 and go to LDSTALL; otherwise stay in RUN.
- **LDSTALL**
  - Assert stall_PC, stall_IFID, bubble_IDEX; increment the counter; decrement the down-counter.
  - Return to RUN when the down-counter reaches 0 after the decrement.
  - mem_Busy=1 overrides: freeze outputs instead of the bubble, the down-counter holds, and the state stays in LDSTALL. The counter does not increment.
  - exe_BranchTaken is ignored; EX holds a bubble.
- **MEMWAIT**
  - Assert all five stall outputs while mem_Busy=1.
  - When mem_Busy=0, deassert everything this cycle and return to RUN. Pending branch/load-use conditions are evaluated normally in this same cycle using RUN rules.
- hazard_StallCnt saturates at 2^CNT_W-1 and never wraps.

## Timing
- Forward selects and all stall/flush/bubble outputs are combinational from current inputs plus the registered state; zero-cycle latency.
- State, down-counter and hazard_StallCnt update on the rising edge of clk.
- rst_n low (asynchronous, any time, including mid-LDSTALL or mid-MEMWAIT):
  - state=RUN, down-counter=0, hazard_StallCnt=0
  - every output is forced to 0 while rst_n is low
- Normal evaluation resumes on the first clk edge after rst_n rises.
- Load-use with LOAD_STALL_CYC=k gives exactly k consecutive bubble cycles. After that, the consumer reaches EX with the load in WB, giving exe_FwdSel=10.

## Test plan
- **EX-EX forward.** mem_RegWrite=1, mem_DMemRead=0, mem_WriteReg=3, exe_ReadReg={op1=3, op0=5}, exe_ReadEn=2'b11, wb_WriteReg=5, wb_RegWrite=1 → exe_FwdSel=4'b0110.
- **Priority and enable.** MEM and WB both write reg 2, exe op0=2 → op0 select 01. Same with exe_ReadEn[0]=0 → op0 select 00. MEM is a load writing 2 → op0 select 10.
- **Load-use, LOAD_STALL_CYC=1.** Load writes r4 in EX, dec op1=r4 → one cycle of stall_PC/stall_IFID/bubble_IDEX, then state RUN and hazard_StallCnt=1. Next cycle consumer in EX gets exe_FwdSel op1=10.
- **Load-use, LOAD_STALL_CYC=3.** Same stimulus → bubbles for exactly 3 cycles, hazard_State 00→01→01→00, hazard_StallCnt=3.
- **Memory freeze during branch.** mem_Busy=1 for 2 cycles with exe_BranchTaken=1 → five stall outputs high and flushes low for 2 cycles, state MEMWAIT. On the cycle mem_Busy=0, flush_IFID=flush_IDEX=1.
- **Reset mid-stall and saturation.** rst_n pulsed low asynchronously during LDSTALL → all outputs 0 immediately, state RUN, counter 0. With CNT_W=2, 5 bubble cycles → hazard_StallCnt=3.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline-side signal bundle for the hazard controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
    parameter int REG_AW = 3,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 16
);
    logic [NUM_RD*REG_AW-1:0] dec_ReadReg;
    logic [NUM_RD-1:0]        dec_ReadEn;
    logic [NUM_RD*REG_AW-1:0] exe_ReadReg;
    logic [NUM_RD-1:0]        exe_ReadEn;
    logic                     exe_RegWrite;
    logic                     exe_DMemRead;
    logic [REG_AW-1:0]        exe_WriteReg;
    logic                     exe_BranchTaken;
    logic                     mem_RegWrite;
    logic                     mem_DMemRead;
    logic [REG_AW-1:0]        mem_WriteReg;
    logic                     mem_Busy;
    logic                     wb_RegWrite;
    logic [REG_AW-1:0]        wb_WriteReg;

    logic [2*NUM_RD-1:0]      exe_FwdSel;
    logic [2*NUM_RD-1:0]      dec_FwdSel;
    logic                     stall_PC;
    logic                     stall_IFID;
    logic                     bubble_IDEX;
    logic                     stall_IDEX;
    logic                     stall_EXMEM;
    logic                     stall_MEMWB;
    logic                     flush_IFID;
    logic                     flush_IDEX;
    logic [1:0]               hazard_State;
    logic [CNT_W-1:0]         hazard_StallCnt;

    modport master (
        output dec_ReadReg, dec_ReadEn, exe_ReadReg, exe_ReadEn,
               exe_RegWrite, exe_DMemRead, exe_WriteReg, exe_BranchTaken,
               mem_RegWrite, mem_DMemRead, mem_WriteReg, mem_Busy,
               wb_RegWrite, wb_WriteReg,
        input  exe_FwdSel, dec_FwdSel, stall_PC, stall_IFID, bubble_IDEX,
               stall_IDEX, stall_EXMEM, stall_MEMWB, flush_IFID, flush_IDEX,
               hazard_State, hazard_StallCnt
    );

    modport slave (
        input  dec_ReadReg, dec_ReadEn, exe_ReadReg, exe_ReadEn,
               exe_RegWrite, exe_DMemRead, exe_WriteReg, exe_BranchTaken,
               mem_RegWrite, mem_DMemRead, mem_WriteReg, mem_Busy,
               wb_RegWrite, wb_WriteReg,
        output exe_FwdSel, dec_FwdSel, stall_PC, stall_IFID, bubble_IDEX,
               stall_IDEX, stall_EXMEM, stall_MEMWB, flush_IFID, flush_IDEX,
               hazard_State, hazard_StallCnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Operand forwarding, load-use/memory-freeze/branch sequencing.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int REG_AW         = 3,
    parameter int NUM_RD         = 2,
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 16
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    hazard_ctrl_if.slave hz
);
    localparam int               c_DW       = (LOAD_STALL_CYC > 1) ? $clog2(LOAD_STALL_CYC) : 1;
    localparam logic [c_DW-1:0]  c_LOAD     = c_DW'(LOAD_STALL_CYC - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_RUN     = 2'b00,
        S_LDSTALL = 2'b01,
        S_MEMWAIT = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_DW-1:0]     r_down;
    logic [c_DW-1:0]     w_down_nx;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_cnt_inc;
    logic                w_freeze;
    logic                w_bubble;
    logic                w_flush;
    logic                w_load_use;
    logic [2*NUM_RD-1:0] w_exe_sel;
    logic [2*NUM_RD-1:0] w_dec_sel;

    // Youngest producer wins; a load in MEM has no result yet, so it is skipped.
    function automatic logic [1:0] fwd_one(
        input logic              en,
        input logic [REG_AW-1:0] src
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (en) begin
            if (hz.mem_RegWrite && !hz.mem_DMemRead && hz.mem_WriteReg == src)
                sel = 2'b01;
            else if (hz.wb_RegWrite && hz.wb_WriteReg == src)
                sel = 2'b10;
        end
        return sel;
    endfunction

    for (genvar i = 0; i < NUM_RD; i++) begin : g_fwd
        assign w_exe_sel[2*i +: 2] = fwd_one(hz.exe_ReadEn[i], hz.exe_ReadReg[i*REG_AW +: REG_AW]);
        assign w_dec_sel[2*i +: 2] = fwd_one(hz.dec_ReadEn[i], hz.dec_ReadReg[i*REG_AW +: REG_AW]);
    end

    always_comb begin
        w_load_use = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (hz.dec_ReadEn[i] && hz.dec_ReadReg[i*REG_AW +: REG_AW] == hz.exe_WriteReg)
                w_load_use = 1'b1;
        end
        w_load_use = w_load_use & hz.exe_DMemRead & hz.exe_RegWrite;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_down  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_down  <= w_down_nx;
            if (w_cnt_inc && r_cnt != c_CNT_MAX)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_next    = r_state;
        w_down_nx = r_down;
        w_freeze  = 1'b0;
        w_bubble  = 1'b0;
        w_flush   = 1'b0;
        w_cnt_inc = 1'b0;
        case (r_state)
            S_LDSTALL: begin
                if (hz.mem_Busy) begin
                    w_freeze = 1'b1;
                end else begin
                    w_bubble  = 1'b1;
                    w_cnt_inc = 1'b1;
                    w_down_nx = r_down - c_DW'(1);
                    if (r_down == c_DW'(1))
                        w_next = S_RUN;
                end
            end
            // MEMWAIT releases straight into RUN rules on the same cycle.
            default: begin
                w_next = S_RUN;
                if (hz.mem_Busy) begin
                    w_freeze = 1'b1;
                    w_next   = S_MEMWAIT;
                end else if (hz.exe_BranchTaken) begin
                    w_flush = 1'b1;
                end else if (w_load_use) begin
                    w_bubble  = 1'b1;
                    w_cnt_inc = 1'b1;
                    if (LOAD_STALL_CYC > 1) begin
                        w_next    = S_LDSTALL;
                        w_down_nx = c_LOAD;
                    end
                end
            end
        endcase
    end

    assign hz.exe_FwdSel      = w_exe_sel & {(2*NUM_RD){rst_n}};
    assign hz.dec_FwdSel      = w_dec_sel & {(2*NUM_RD){rst_n}};
    assign hz.stall_PC        = rst_n & (w_freeze | w_bubble);
    assign hz.stall_IFID      = rst_n & (w_freeze | w_bubble);
    assign hz.bubble_IDEX     = rst_n & w_bubble;
    assign hz.stall_IDEX      = rst_n & w_freeze;
    assign hz.stall_EXMEM     = rst_n & w_freeze;
    assign hz.stall_MEMWB     = rst_n & w_freeze;
    assign hz.flush_IFID      = rst_n & w_flush;
    assign hz.flush_IDEX      = rst_n & w_flush;
    assign hz.hazard_State    = r_state & {2{rst_n}};
    assign hz.hazard_StallCnt = r_cnt & {CNT_W{rst_n}};

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed bench; two DUT configurations share one stimulus.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
    localparam int RA = 3;
    localparam int NR = 2;

    typedef struct packed {
        logic       spc, sifid, bub, sidex, sexmem, smemwb, fifid, fidex;
        logic [1:0] st;
    } ctl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR*RA-1:0] dec_rr, exe_rr;
    logic [NR-1:0]    dec_en, exe_en;
    logic             exe_rw, exe_dr, exe_br, mem_rw, mem_dr, mem_busy, wb_rw;
    logic [RA-1:0]    exe_wr, mem_wr, wb_wr;

    hazard_ctrl_if #(.REG_AW(RA), .NUM_RD(NR), .CNT_W(16)) ifa ();
    hazard_ctrl_if #(.REG_AW(RA), .NUM_RD(NR), .CNT_W(2))  ifb ();

    assign ifa.dec_ReadReg = dec_rr;  assign ifb.dec_ReadReg = dec_rr;
    assign ifa.dec_ReadEn  = dec_en;  assign ifb.dec_ReadEn  = dec_en;
    assign ifa.exe_ReadReg = exe_rr;  assign ifb.exe_ReadReg = exe_rr;
    assign ifa.exe_ReadEn  = exe_en;  assign ifb.exe_ReadEn  = exe_en;
    assign ifa.exe_RegWrite = exe_rw; assign ifb.exe_RegWrite = exe_rw;
    assign ifa.exe_DMemRead = exe_dr; assign ifb.exe_DMemRead = exe_dr;
    assign ifa.exe_WriteReg = exe_wr; assign ifb.exe_WriteReg = exe_wr;
    assign ifa.exe_BranchTaken = exe_br; assign ifb.exe_BranchTaken = exe_br;
    assign ifa.mem_RegWrite = mem_rw; assign ifb.mem_RegWrite = mem_rw;
    assign ifa.mem_DMemRead = mem_dr; assign ifb.mem_DMemRead = mem_dr;
    assign ifa.mem_WriteReg = mem_wr; assign ifb.mem_WriteReg = mem_wr;
    assign ifa.mem_Busy    = mem_busy; assign ifb.mem_Busy   = mem_busy;
    assign ifa.wb_RegWrite = wb_rw;   assign ifb.wb_RegWrite = wb_rw;
    assign ifa.wb_WriteReg = wb_wr;   assign ifb.wb_WriteReg = wb_wr;

    hazard_ctrl #(.REG_AW(RA), .NUM_RD(NR), .LOAD_STALL_CYC(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .hz(ifa));
    hazard_ctrl #(.REG_AW(RA), .NUM_RD(NR), .LOAD_STALL_CYC(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .hz(ifb));

    ctl_t        act [2];
    logic [15:0] act_cnt [2];
    logic [3:0]  act_exe [2];
    logic [3:0]  act_dec [2];
    assign act[0] = {ifa.stall_PC, ifa.stall_IFID, ifa.bubble_IDEX, ifa.stall_IDEX,
                     ifa.stall_EXMEM, ifa.stall_MEMWB, ifa.flush_IFID, ifa.flush_IDEX, ifa.hazard_State};
    assign act[1] = {ifb.stall_PC, ifb.stall_IFID, ifb.bubble_IDEX, ifb.stall_IDEX,
                     ifb.stall_EXMEM, ifb.stall_MEMWB, ifb.flush_IFID, ifb.flush_IDEX, ifb.hazard_State};
    assign act_cnt[0] = ifa.hazard_StallCnt;
    assign act_cnt[1] = {14'b0, ifb.hazard_StallCnt};
    assign act_exe[0] = ifa.exe_FwdSel; assign act_exe[1] = ifb.exe_FwdSel;
    assign act_dec[0] = ifa.dec_FwdSel; assign act_dec[1] = ifb.dec_FwdSel;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int k, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, k, $time, a, e);
    endtask

    // ---------------- behavioural model ----------------
    int lsc  [2] = '{1, 3};
    int cmax [2] = '{65535, 3};
    int m_left [2];   // bubble cycles still owed after the current one
    int m_cnt  [2];
    bit m_frz  [2];   // previous cycle was a freeze outside a load-use stall

    function automatic bit lu();
        bit h = 0;
        for (int i = 0; i < NR; i++)
            if (dec_en[i] && dec_rr[i*RA +: RA] == exe_wr) h = 1;
        return h && exe_dr && exe_rw;
    endfunction

    function automatic logic [3:0] fwd(input logic [NR*RA-1:0] rr, input logic [NR-1:0] en);
        logic [3:0] s = '0;
        for (int i = 0; i < NR; i++) begin
            if (!en[i]) continue;
            if (mem_rw && !mem_dr && mem_wr == rr[i*RA +: RA]) s[2*i +: 2] = 2'b01;
            else if (wb_rw && wb_wr == rr[i*RA +: RA])        s[2*i +: 2] = 2'b10;
        end
        return s;
    endfunction

    function automatic ctl_t exp_ctl(input int k);
        ctl_t c = '0;
        bit frz, bub;
        if (m_left[k] > 0) begin
            c.st = 2'b01;
            frz = mem_busy; bub = !mem_busy;
        end else begin
            c.st = m_frz[k] ? 2'b10 : 2'b00;
            frz = mem_busy;
            bub = !mem_busy && !exe_br && lu();
            c.fifid = !mem_busy && exe_br;
            c.fidex = c.fifid;
        end
        c.spc = frz || bub; c.sifid = frz || bub; c.bub = bub;
        c.sidex = frz; c.sexmem = frz; c.smemwb = frz;
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_left[k] <= 0; m_cnt[k] <= 0; m_frz[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_left[k] > 0) begin
                    m_frz[k] <= 0;
                    if (!mem_busy) begin
                        m_left[k] <= m_left[k] - 1;
                        m_cnt[k]  <= (m_cnt[k] < cmax[k]) ? m_cnt[k] + 1 : m_cnt[k];
                    end
                end else begin
                    m_frz[k] <= mem_busy;
                    if (!mem_busy && !exe_br && lu()) begin
                        m_left[k] <= lsc[k] - 1;
                        m_cnt[k]  <= (m_cnt[k] < cmax[k]) ? m_cnt[k] + 1 : m_cnt[k];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check("ctl",     k, 32'(act[k]),     rst_n ? 32'(exp_ctl(k)) : 32'd0);
            check("exe_fwd", k, 32'(act_exe[k]), rst_n ? 32'(fwd(exe_rr, exe_en)) : 32'd0);
            check("dec_fwd", k, 32'(act_dec[k]), rst_n ? 32'(fwd(dec_rr, dec_en)) : 32'd0);
            check("cnt",     k, 32'(act_cnt[k]), rst_n ? 32'(m_cnt[k]) : 32'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic clr();
        dec_rr = '0; dec_en = '0; exe_rr = '0; exe_en = '0;
        exe_rw = 0; exe_dr = 0; exe_br = 0; exe_wr = '0;
        mem_rw = 0; mem_dr = 0; mem_wr = '0; mem_busy = 0;
        wb_rw = 0; wb_wr = '0;
    endtask

    task automatic set_load_use();
        exe_dr = 1; exe_rw = 1; exe_wr = 3'd4;
        dec_rr = {3'd4, 3'd1}; dec_en = 2'b11;
    endtask

    initial begin
        clr();
        cyc(); cyc();
        rst_n = 1;

        cyc(); mem_rw = 1; mem_wr = 3'd3; exe_rr = {3'd3, 3'd5}; exe_en = 2'b11;
        wb_rw = 1; wb_wr = 3'd5; dec_rr = {3'd5, 3'd3}; dec_en = 2'b01; #2;
        check("exex_fwd", 0, 32'(ifa.exe_FwdSel), 32'b0110);
        check("dec_fwd_lit", 0, 32'(ifa.dec_FwdSel), 32'b0001);

        cyc(); mem_wr = 3'd2; wb_wr = 3'd2; exe_rr = {3'd7, 3'd2}; #2;
        check("prio_mem", 0, 32'(ifa.exe_FwdSel), 32'b0001);
        cyc(); exe_en = 2'b10; #2;
        check("en_off", 0, 32'(ifa.exe_FwdSel), 32'b0000);
        cyc(); exe_en = 2'b11; mem_dr = 1; #2;
        check("mem_load_wb", 0, 32'(ifa.exe_FwdSel), 32'b0010);

        cyc(); clr(); set_load_use(); #2;
        check("lu1_bubble", 0, 32'(ifa.bubble_IDEX), 32'd1);
        check("lu1_stallpc", 0, 32'(ifa.stall_PC), 32'd1);
        check("lu3_st0", 1, 32'(ifb.hazard_State), 32'd0);
        check("lu3_bub0", 1, 32'(ifb.bubble_IDEX), 32'd1);
        cyc(); exe_dr = 0; exe_rw = 0; exe_wr = '0; mem_rw = 1; mem_dr = 1; mem_wr = 3'd4; #2;
        check("lu1_done", 0, 32'(ifa.bubble_IDEX), 32'd0);
        check("lu1_state", 0, 32'(ifa.hazard_State), 32'd0);
        check("lu1_cnt", 0, 32'(ifa.hazard_StallCnt), 32'd1);
        check("lu3_st1", 1, 32'(ifb.hazard_State), 32'd1);
        check("lu3_bub1", 1, 32'(ifb.bubble_IDEX), 32'd1);
        cyc(); mem_rw = 0; mem_dr = 0; mem_wr = '0; wb_rw = 1; wb_wr = 3'd4;
        exe_rr = {3'd4, 3'd1}; exe_en = 2'b11; dec_en = '0; #2;
        check("lu1_fwd_wb", 0, 32'(ifa.exe_FwdSel), 32'b1000);
        check("lu3_st2", 1, 32'(ifb.hazard_State), 32'd1);
        check("lu3_bub2", 1, 32'(ifb.bubble_IDEX), 32'd1);
        cyc(); clr(); #2;
        check("lu3_st3", 1, 32'(ifb.hazard_State), 32'd0);
        check("lu3_bub3", 1, 32'(ifb.bubble_IDEX), 32'd0);
        check("lu3_cnt", 1, 32'(ifb.hazard_StallCnt), 32'd3);

        cyc(); mem_busy = 1; exe_br = 1; #2;
        check("frz_memwb", 0, 32'(ifa.stall_MEMWB), 32'd1);
        check("frz_noflush", 0, 32'(ifa.flush_IFID), 32'd0);
        check("frz_st0", 0, 32'(ifa.hazard_State), 32'd0);
        cyc(); #2;
        check("frz_st1", 0, 32'(ifa.hazard_State), 32'd2);
        check("frz_idex", 0, 32'(ifa.stall_IDEX), 32'd1);
        cyc(); mem_busy = 0; #2;
        check("rel_flush_ifid", 0, 32'(ifa.flush_IFID), 32'd1);
        check("rel_flush_idex", 0, 32'(ifa.flush_IDEX), 32'd1);
        check("rel_nostall", 0, 32'(ifa.stall_PC), 32'd0);
        cyc(); clr(); #2;
        check("rel_run", 0, 32'(ifa.hazard_State), 32'd0);

        cyc(); set_load_use();
        cyc(); clr(); mem_busy = 1; #2;
        check("ldfrz_st", 1, 32'(ifb.hazard_State), 32'd1);
        check("ldfrz_nobub", 1, 32'(ifb.bubble_IDEX), 32'd0);
        check("ldfrz_exmem", 1, 32'(ifb.stall_EXMEM), 32'd1);
        cyc(); mem_busy = 0; #2;
        check("ldfrz_resume", 1, 32'(ifb.bubble_IDEX), 32'd1);
        cyc(); cyc(); #2;
        check("ldfrz_run", 1, 32'(ifb.hazard_State), 32'd0);

        cyc(); set_load_use(); wb_rw = 1; wb_wr = 3'd1; exe_rr = {3'd0, 3'd1}; exe_en = 2'b01;
        cyc(); #2;
        rst_n = 0; #1;
        check("rst_st", 1, 32'(ifb.hazard_State), 32'd0);
        check("rst_bub", 1, 32'(ifb.bubble_IDEX), 32'd0);
        check("rst_spc", 1, 32'(ifb.stall_PC), 32'd0);
        check("rst_cnt", 1, 32'(ifb.hazard_StallCnt), 32'd0);
        check("rst_bub_a", 0, 32'(ifa.bubble_IDEX), 32'd0);
        check("rst_fwd_a", 0, 32'(ifa.exe_FwdSel), 32'd0);
        cyc(); #1 rst_n = 1;
        repeat (6) cyc();
        clr(); #2;
        check("sat_cnt", 1, 32'(ifb.hazard_StallCnt), 32'd3);
        check("cnt_6", 0, 32'(ifa.hazard_StallCnt), 32'd6);

        cyc(); cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
